capture_sequencer: RTL and testbench

Sequences one acquisition of the 4-channel logic analyzer. It writes channel samples into an external circular sample RAM at the rate of the selected sample clock, then waits for a pattern trigger. After the trigger it fills the rest of the buffer with post-trigger samples. Once the capture is complete it streams the DEPTH samples, oldest first, out through a valid/ready port to the upload path. It sits between the sample-clock selection logic (source of smpl_en), the sample RAM and the host/UART readout.

---
 rtl/capture_pkg.sv | 27 ++
 rtl/capture_readout.sv | 105 ++++++++++
 rtl/capture_sequencer.sv | 200 ++++++++++++++++++++
 tb/tb_capture_sequencer.sv | 519 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/capture_pkg.sv
// capture_pkg
// Shared definitions for the logic-analyzer capture sequencer.
//   - 3-bit state encodings, also used by the status LED decoder
//   - trig_match(): pattern comparison used by the trigger logic
// Ports: none (package).
package capture_pkg;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_PRE_FILL  = 3'd1;
    localparam logic [2:0] ST_WAIT_TRIG = 3'd2;
    localparam logic [2:0] ST_POST      = 3'd3;
    localparam logic [2:0] ST_DONE      = 3'd4;
    localparam logic [2:0] ST_RD_ISSUE  = 3'd5;
    localparam logic [2:0] ST_RD_WAIT   = 3'd6;
    localparam logic [2:0] ST_RD_HOLD   = 3'd7;

    // Widest channel count trig_match() accepts; callers zero-extend.
    localparam int TRIG_W = 32;

    // True when every masked channel carries its required level.
    function automatic logic trig_match(input logic [TRIG_W-1:0] data,
                                        input logic [TRIG_W-1:0] val,
                                        input logic [TRIG_W-1:0] mask);
        return ((data ^ val) & mask) == '0;
    endfunction

endpackage

// File: rtl/capture_readout.sv
// capture_readout
// Streams DEPTH samples out of the sample RAM, oldest first, through a
// valid/ready port. One sample takes at least three clocks:
// issue read, wait for RAM data, hold until accepted.
// Ports:
//   clk, reset        system clock, asynchronous active-low reset
//   abort_i           returns to idle on the next edge
//   start_i           one-clk start pulse, start_addr_i = first read address
//   ram_rdata_i       RAM read data, valid one clk after ram_re_o
//   o_ready_i         downstream accepts o_data_o
//   ram_re_o          RAM read enable, ram_raddr_o read address
//   o_data_o/o_valid_o/o_last_o  readout stream
//   done_o            final sample accepted this clk
//   state_o           ST_IDLE or one of the ST_RD_* encodings
module capture_readout
    import capture_pkg::*;
#(
    parameter int N_CH   = 4,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              abort_i,
    input  logic              start_i,
    input  logic [ADDR_W-1:0] start_addr_i,
    input  logic [N_CH-1:0]   ram_rdata_i,
    input  logic              o_ready_i,
    output logic              ram_re_o,
    output logic [ADDR_W-1:0] ram_raddr_o,
    output logic [N_CH-1:0]   o_data_o,
    output logic              o_valid_o,
    output logic              o_last_o,
    output logic              done_o,
    output logic [2:0]        state_o
);

    logic [2:0]        state_q, state_d;
    logic [ADDR_W-1:0] rptr_q, rptr_d;
    logic [ADDR_W-1:0] rcnt_q, rcnt_d;
    logic [N_CH-1:0]   data_q, data_d;
    logic              last_cnt;

    // The read count is ADDR_W wide, so all-ones is DEPTH-1: the final sample.
    assign last_cnt    = (rcnt_q == '1);
    assign o_valid_o   = (state_q == ST_RD_HOLD);
    assign o_last_o    = o_valid_o && last_cnt;
    assign done_o      = o_last_o && o_ready_i;
    assign ram_re_o    = (state_q == ST_RD_ISSUE);
    assign ram_raddr_o = rptr_q;
    assign o_data_o    = data_q;
    assign state_o     = state_q;

    // Next-state logic; abort overrides everything and drops o_valid next clk.
    always_comb begin
        state_d = state_q;
        rptr_d  = rptr_q;
        rcnt_d  = rcnt_q;
        data_d  = data_q;
        if (abort_i) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        rptr_d  = start_addr_i;
                        rcnt_d  = '0;
                        state_d = ST_RD_ISSUE;
                    end
                end
                ST_RD_ISSUE: state_d = ST_RD_WAIT;
                ST_RD_WAIT: begin
                    data_d  = ram_rdata_i;
                    state_d = ST_RD_HOLD;
                end
                ST_RD_HOLD: begin
                    if (o_ready_i) begin
                        if (last_cnt) begin
                            state_d = ST_IDLE;
                        end else begin
                            rptr_d  = rptr_q + 1'b1;
                            rcnt_d  = rcnt_q + 1'b1;
                            state_d = ST_RD_ISSUE;
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            rptr_q  <= '0;
            rcnt_q  <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            rptr_q  <= rptr_d;
            rcnt_q  <= rcnt_d;
            data_q  <= data_d;
        end
    end

endmodule

// File: rtl/capture_sequencer.sv
// capture_sequencer
// Runs one acquisition: pre-trigger fill of a circular sample RAM, trigger
// wait, post-trigger fill, then readout of the whole buffer oldest first.
// Ports:
//   clk, reset                      system clock, asynchronous active-low reset
//   smpl_en, ch_data                sample strobe and channel levels
//   arm, abort, rd_start            control pulses
//   trig_mask, trig_val             trigger pattern
//   ram_we/ram_waddr/ram_wdata      RAM write port (registered)
//   ram_re/ram_raddr/ram_rdata      RAM read port, one clk read latency
//   o_data/o_valid/o_ready/o_last   readout stream
//   state_o, busy                   status
module capture_sequencer
    import capture_pkg::*;
#(
    parameter int N_CH        = 4,
    parameter int ADDR_W      = 10,
    parameter int PRE_SAMPLES = 256
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              smpl_en,
    input  logic [N_CH-1:0]   ch_data,
    input  logic              arm,
    input  logic              abort,
    input  logic [N_CH-1:0]   trig_mask,
    input  logic [N_CH-1:0]   trig_val,
    input  logic              rd_start,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_waddr,
    output logic [N_CH-1:0]   ram_wdata,
    output logic              ram_re,
    output logic [ADDR_W-1:0] ram_raddr,
    input  logic [N_CH-1:0]   ram_rdata,
    output logic [N_CH-1:0]   o_data,
    output logic              o_valid,
    input  logic              o_ready,
    output logic              o_last,
    output logic [2:0]        state_o,
    output logic              busy
);

    localparam int DEPTH        = 2 ** ADDR_W;
    localparam int POST_SAMPLES = DEPTH - PRE_SAMPLES;
    localparam int CNT_W        = ADDR_W + 1;
    localparam logic [CNT_W-1:0] PRE_LAST  = CNT_W'(PRE_SAMPLES - 1);
    localparam logic [CNT_W-1:0] POST_LAST = CNT_W'(POST_SAMPLES - 1);

    logic [2:0]        state_q, state_d;
    logic [ADDR_W-1:0] wptr_q, wptr_d;
    logic [ADDR_W-1:0] trig_addr_q, trig_addr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              match_prev_q, match_prev_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [N_CH-1:0]   wdata_q, wdata_d;

    logic              capturing;
    logic              write_sample;
    logic              match;
    logic              rd_start_pulse;
    logic              rd_done;
    logic [ADDR_W-1:0] rd_start_addr;
    logic [2:0]        rd_state;

    assign capturing    = (state_q == ST_PRE_FILL) || (state_q == ST_WAIT_TRIG) ||
                          (state_q == ST_POST);
    assign write_sample = capturing && smpl_en && !abort;
    assign match        = trig_match(TRIG_W'(ch_data), TRIG_W'(trig_val), TRIG_W'(trig_mask));

    // Oldest retained sample sits PRE_SAMPLES before the trigger; the
    // ADDR_W-wide subtraction gives the modulo-DEPTH wrap for free.
    assign rd_start_addr  = trig_addr_q - ADDR_W'(PRE_SAMPLES);
    assign rd_start_pulse = (state_q == ST_DONE) && rd_start && !abort;

    assign ram_we    = we_q;
    assign ram_waddr = waddr_q;
    assign ram_wdata = wdata_q;
    assign busy      = (state_q != ST_IDLE) && (state_q != ST_DONE);

    // While reading, this FSM parks in ST_RD_ISSUE and the readout block
    // reports the actual read phase.
    assign state_o = (state_q == ST_RD_ISSUE) ? rd_state : state_q;

    // Capture FSM and write path. The write port is registered, so a sample
    // strobed this clk appears on ram_we/ram_waddr/ram_wdata next clk.
    always_comb begin
        state_d      = state_q;
        wptr_d       = wptr_q;
        trig_addr_d  = trig_addr_q;
        cnt_d        = cnt_q;
        match_prev_d = match_prev_q;
        we_d         = write_sample;
        waddr_d      = waddr_q;
        wdata_d      = wdata_q;
        if (write_sample) begin
            waddr_d = wptr_q;
            wdata_d = ch_data;
            wptr_d  = wptr_q + 1'b1;
        end
        if (abort) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (arm) begin
                        state_d = ST_PRE_FILL;
                        wptr_d  = '0;
                        cnt_d   = '0;
                    end
                end
                ST_PRE_FILL: begin
                    if (smpl_en) begin
                        if (cnt_q == PRE_LAST) begin
                            state_d      = ST_WAIT_TRIG;
                            cnt_d        = '0;
                            match_prev_d = 1'b0;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end
                ST_WAIT_TRIG: begin
                    // Rising edge of the pattern match fires the trigger.
                    if (smpl_en) begin
                        if (match && !match_prev_q) begin
                            trig_addr_d = wptr_q;
                            cnt_d       = CNT_W'(1);
                            state_d     = (POST_SAMPLES == 1) ? ST_DONE : ST_POST;
                        end else begin
                            match_prev_d = match;
                        end
                    end
                end
                ST_POST: begin
                    if (smpl_en) begin
                        cnt_d = cnt_q + 1'b1;
                        if (cnt_q == POST_LAST) begin
                            state_d = ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    if (rd_start) begin
                        state_d = ST_RD_ISSUE;
                    end
                end
                ST_RD_ISSUE: begin
                    if (rd_done) begin
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            wptr_q       <= '0;
            trig_addr_q  <= '0;
            cnt_q        <= '0;
            match_prev_q <= 1'b0;
            we_q         <= 1'b0;
            waddr_q      <= '0;
            wdata_q      <= '0;
        end else begin
            state_q      <= state_d;
            wptr_q       <= wptr_d;
            trig_addr_q  <= trig_addr_d;
            cnt_q        <= cnt_d;
            match_prev_q <= match_prev_d;
            we_q         <= we_d;
            waddr_q      <= waddr_d;
            wdata_q      <= wdata_d;
        end
    end

    capture_readout #(
        .N_CH   (N_CH),
        .ADDR_W (ADDR_W)
    ) u_readout (
        .clk          (clk),
        .reset        (reset),
        .abort_i      (abort),
        .start_i      (rd_start_pulse),
        .start_addr_i (rd_start_addr),
        .ram_rdata_i  (ram_rdata),
        .o_ready_i    (o_ready),
        .ram_re_o     (ram_re),
        .ram_raddr_o  (ram_raddr),
        .o_data_o     (o_data),
        .o_valid_o    (o_valid),
        .o_last_o     (o_last),
        .done_o       (rd_done),
        .state_o      (rd_state)
    );

endmodule

// File: tb/tb_capture_sequencer.sv
// tb_capture_sequencer
// Self-checking bench for capture_sequencer with ADDR_W=4, PRE_SAMPLES=4.
// Expected RAM writes, read addresses and readout samples are queued as
// stimulus is driven and checked by monitors when the DUT produces them.
module tb_capture_sequencer;

    logic       clk;
    logic       reset;
    logic       smpl_en;
    logic [3:0] ch_data;
    logic       arm;
    logic       abort;
    logic [3:0] trig_mask;
    logic [3:0] trig_val;
    logic       rd_start;
    logic       ram_we;
    logic [3:0] ram_waddr;
    logic [3:0] ram_wdata;
    logic       ram_re;
    logic [3:0] ram_raddr;
    logic [3:0] ram_rdata;
    logic [3:0] o_data;
    logic       o_valid;
    logic       o_ready;
    logic       o_last;
    logic [2:0] state_o;
    logic       busy;

    int testsRun = 0;
    int testsFailed = 0;
    int rdSeen = 0;
    int reSeen = 0;

    logic [7:0] expWrQ[$];
    logic [3:0] expAddrQ[$];
    logic [4:0] expRdQ[$];

    logic [3:0] modelMem[16];
    logic [3:0] ramMem[16];
    int modelWptr = 0;
    int modelTrig = 0;

    logic [7:0] wrExp;
    logic [3:0] addrExp;
    logic [4:0] rdExp;

    capture_sequencer #(
        .N_CH        (4),
        .ADDR_W      (4),
        .PRE_SAMPLES (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .smpl_en   (smpl_en),
        .ch_data   (ch_data),
        .arm       (arm),
        .abort     (abort),
        .trig_mask (trig_mask),
        .trig_val  (trig_val),
        .rd_start  (rd_start),
        .ram_we    (ram_we),
        .ram_waddr (ram_waddr),
        .ram_wdata (ram_wdata),
        .ram_re    (ram_re),
        .ram_raddr (ram_raddr),
        .ram_rdata (ram_rdata),
        .o_data    (o_data),
        .o_valid   (o_valid),
        .o_ready   (o_ready),
        .o_last    (o_last),
        .state_o   (state_o),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External sample RAM: synchronous write, one-clk read latency.
    initial begin
        for (int i = 0; i < 16; i++) ramMem[i] = 4'h0;
        ram_rdata = 4'h0;
    end
    always @(posedge clk) begin
        if (ram_we) ramMem[ram_waddr] <= ram_wdata;
        if (ram_re) ram_rdata <= ramMem[ram_raddr];
    end

    // Write monitor.
    always @(negedge clk) begin
        if (reset && ram_we) begin
            testsRun++;
            if (expWrQ.size() == 0) begin
                testsFailed++;
                $display("[TB] FAIL write_unexpected: got addr=%0d data=%h, required no write",
                         ram_waddr, ram_wdata);
            end else begin
                wrExp = expWrQ.pop_front();
                if ({ram_waddr, ram_wdata} !== wrExp) begin
                    testsFailed++;
                    $display("[TB] FAIL write_data: got addr=%0d data=%h, required addr=%0d data=%h",
                             ram_waddr, ram_wdata, wrExp[7:4], wrExp[3:0]);
                end
            end
        end
    end

    // Read-address monitor.
    always @(negedge clk) begin
        if (reset && ram_re) begin
            reSeen++;
            testsRun++;
            if (expAddrQ.size() == 0) begin
                testsFailed++;
                $display("[TB] FAIL read_unexpected: got raddr=%0d, required no read", ram_raddr);
            end else begin
                addrExp = expAddrQ.pop_front();
                if (ram_raddr !== addrExp) begin
                    testsFailed++;
                    $display("[TB] FAIL read_addr: got %0d, required %0d", ram_raddr, addrExp);
                end
            end
        end
    end

    // Readout handshake monitor; inputs only change just after posedge.
    always @(negedge clk) begin
        if (reset && o_valid && o_ready) begin
            rdSeen++;
            testsRun++;
            if (expRdQ.size() == 0) begin
                testsFailed++;
                $display("[TB] FAIL readout_unexpected: got data=%h last=%b", o_data, o_last);
            end else begin
                rdExp = expRdQ.pop_front();
                if ({o_last, o_data} !== rdExp) begin
                    testsFailed++;
                    $display("[TB] FAIL readout_sample %0d: got data=%h last=%b, required data=%h last=%b",
                             rdSeen, o_data, o_last, rdExp[3:0], rdExp[4]);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic pulse_ctrl(input bit a, input bit ab, input bit rs);
        @(posedge clk); #1;
        arm = a; abort = ab; rd_start = rs;
        @(posedge clk); #1;
        arm = 1'b0; abort = 1'b0; rd_start = 1'b0;
    endtask

    // One sample strobe; when a write is expected it is queued and mirrored.
    task automatic send_sample(input logic [3:0] d, input bit expWrite);
        @(posedge clk); #1;
        ch_data = d;
        smpl_en = 1'b1;
        if (expWrite) begin
            expWrQ.push_back({4'(modelWptr), d});
            modelMem[modelWptr] = d;
            modelWptr = (modelWptr + 1) % 16;
        end
        @(posedge clk); #1;
        smpl_en = 1'b0;
    endtask

    task automatic run_readout(input int stallAt);
        int start;
        int a;
        bit stalled;
        bit finished;
        bit bad;
        int reBefore;
        logic [3:0] held;
        start = (modelTrig - 4 + 16) % 16;
        for (int i = 0; i < 16; i++) begin
            a = (start + i) % 16;
            expAddrQ.push_back(4'(a));
            expRdQ.push_back({(i == 15) ? 1'b1 : 1'b0, modelMem[a]});
        end
        rdSeen = 0;
        o_ready = 1'b1;
        pulse_ctrl(1'b0, 1'b0, 1'b1);
        testsRun++;
        if (state_o !== 3'd5 || busy !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL done_to_rd_issue: got state=%0d busy=%b, required state=5 busy=1",
                     state_o, busy);
        end
        stalled = 1'b0;
        finished = 1'b0;
        for (int cyc = 0; cyc < 200 && !finished; cyc++) begin
            @(posedge clk); #1;
            if (state_o == 3'd0) begin
                finished = 1'b1;
            end else if (stallAt >= 0 && !stalled && rdSeen == stallAt && o_valid) begin
                stalled = 1'b1;
                o_ready = 1'b0;
                held = o_data;
                reBefore = reSeen;
                bad = 1'b0;
                repeat (10) begin
                    @(posedge clk); #1;
                    if (o_valid !== 1'b1 || o_data !== held) bad = 1'b1;
                end
                testsRun++;
                if (bad) begin
                    testsFailed++;
                    $display("[TB] FAIL stall_hold: got valid=%b data=%h, required valid=1 data=%h",
                             o_valid, o_data, held);
                end
                testsRun++;
                if (reSeen != reBefore) begin
                    testsFailed++;
                    $display("[TB] FAIL stall_no_re: got %0d reads, required 0", reSeen - reBefore);
                end
                o_ready = 1'b1;
            end
        end
        testsRun++;
        if (!finished) begin
            testsFailed++;
            $display("[TB] FAIL readout_timeout: got state=%0d, required 0 within 200 clks", state_o);
        end
        testsRun++;
        if (rdSeen != 16) begin
            testsFailed++;
            $display("[TB] FAIL readout_count: got %0d, required 16", rdSeen);
        end
    endtask

    task automatic test_reset;
        reset = 1'b0;
        smpl_en = 1'b0; ch_data = 4'h0; arm = 1'b0; abort = 1'b0;
        trig_mask = 4'h0; trig_val = 4'h0; rd_start = 1'b0; o_ready = 1'b0;
        #22;
        testsRun++;
        if ({ram_we, ram_waddr, ram_wdata, ram_re, ram_raddr, o_data, o_valid, o_last,
             state_o, busy} !== 24'h0) begin
            testsFailed++;
            $display("[TB] FAIL reset_outputs: got state=%0d we=%b re=%b valid=%b data=%h, required all 0",
                     state_o, ram_we, ram_re, o_valid, o_data);
        end
        reset = 1'b1;
    endtask

    task automatic test_basic_capture;
        trig_mask = 4'b0001;
        trig_val = 4'b0001;
        pulse_ctrl(1'b1, 1'b0, 1'b0);
        modelWptr = 0;
        testsRun++;
        if (state_o !== 3'd1 || busy !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL arm_to_prefill: got state=%0d busy=%b, required state=1 busy=1",
                     state_o, busy);
        end
        send_sample(4'd1, 1'b1);
        testsRun++;
        if (state_o !== 3'd1) begin
            testsFailed++;
            $display("[TB] FAIL prefill_ignores_trigger: got state=%0d, required 1", state_o);
        end
        for (int d = 2; d <= 4; d++) send_sample(4'(d), 1'b1);
        testsRun++;
        if (state_o !== 3'd2) begin
            testsFailed++;
            $display("[TB] FAIL prefill_to_wait: got state=%0d, required 2", state_o);
        end
        modelTrig = modelWptr;
        send_sample(4'd5, 1'b1);
        testsRun++;
        if (state_o !== 3'd3) begin
            testsFailed++;
            $display("[TB] FAIL trigger_on_5: got state=%0d, required 3", state_o);
        end
        for (int d = 6; d <= 15; d++) send_sample(4'(d), 1'b1);
        testsRun++;
        if (state_o !== 3'd3) begin
            testsFailed++;
            $display("[TB] FAIL post_before_full: got state=%0d, required 3", state_o);
        end
        send_sample(4'd0, 1'b1);
        testsRun++;
        if (state_o !== 3'd4 || busy !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL done_after_16: got state=%0d busy=%b, required state=4 busy=0",
                     state_o, busy);
        end
        run_readout(-1);
    endtask

    task automatic test_pattern_present;
        trig_mask = 4'hF;
        trig_val = 4'hA;
        pulse_ctrl(1'b1, 1'b0, 1'b0);
        modelWptr = 0;
        for (int i = 0; i < 4; i++) send_sample(4'hA, 1'b1);
        send_sample(4'hA, 1'b1);
        testsRun++;
        if (state_o !== 3'd3) begin
            testsFailed++;
            $display("[TB] FAIL present_fires_first: got state=%0d, required 3", state_o);
        end
        pulse_ctrl(1'b0, 1'b1, 1'b0);
        trig_mask = 4'h0;
        trig_val = 4'h0;
        pulse_ctrl(1'b1, 1'b0, 1'b0);
        modelWptr = 0;
        for (int i = 0; i < 4; i++) send_sample(4'h7, 1'b1);
        send_sample(4'h7, 1'b1);
        testsRun++;
        if (state_o !== 3'd3) begin
            testsFailed++;
            $display("[TB] FAIL mask_zero_fires_first: got state=%0d, required 3", state_o);
        end
        pulse_ctrl(1'b0, 1'b1, 1'b0);
        trig_mask = 4'hF;
        trig_val = 4'h3;
        pulse_ctrl(1'b1, 1'b0, 1'b0);
        modelWptr = 0;
        for (int i = 0; i < 4; i++) send_sample(4'h3, 1'b1);
        send_sample(4'hA, 1'b1);
        testsRun++;
        if (state_o !== 3'd2) begin
            testsFailed++;
            $display("[TB] FAIL nonmatch_stays: got state=%0d, required 2", state_o);
        end
        send_sample(4'h3, 1'b1);
        testsRun++;
        if (state_o !== 3'd3) begin
            testsFailed++;
            $display("[TB] FAIL match_fires: got state=%0d, required 3", state_o);
        end
        pulse_ctrl(1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_wrap_trigger;
        trig_mask = 4'hF;
        trig_val = 4'hF;
        pulse_ctrl(1'b1, 1'b0, 1'b0);
        modelWptr = 0;
        for (int k = 0; k <= 14; k++) send_sample(4'(k), 1'b1);
        testsRun++;
        if (state_o !== 3'd2) begin
            testsFailed++;
            $display("[TB] FAIL no_trigger_before_15: got state=%0d, required 2", state_o);
        end
        modelTrig = modelWptr;
        send_sample(4'hF, 1'b1);
        testsRun++;
        if (state_o !== 3'd3) begin
            testsFailed++;
            $display("[TB] FAIL trigger_at_15: got state=%0d, required 3", state_o);
        end
        for (int j = 0; j <= 10; j++) send_sample(4'(j), 1'b1);
        testsRun++;
        if (state_o !== 3'd4) begin
            testsFailed++;
            $display("[TB] FAIL wrap_done: got state=%0d, required 4", state_o);
        end
        run_readout(5);
    endtask

    task automatic test_abort;
        bit seen;
        trig_mask = 4'h0;
        trig_val = 4'h0;
        pulse_ctrl(1'b1, 1'b0, 1'b0);
        modelWptr = 0;
        for (int i = 0; i < 4; i++) send_sample(4'h2, 1'b1);
        send_sample(4'h3, 1'b1);
        send_sample(4'h4, 1'b1);
        @(posedge clk); #1;
        smpl_en = 1'b1; abort = 1'b1; ch_data = 4'h9;
        @(posedge clk); #1;
        smpl_en = 1'b0; abort = 1'b0;
        testsRun++;
        if (state_o !== 3'd0 || ram_we !== 1'b0 || busy !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL abort_in_post: got state=%0d we=%b busy=%b, required 0 0 0",
                     state_o, ram_we, busy);
        end
        pulse_ctrl(1'b1, 1'b0, 1'b0);
        modelWptr = 0;
        send_sample(4'h6, 1'b1);
        testsRun++;
        if (state_o !== 3'd1) begin
            testsFailed++;
            $display("[TB] FAIL rearm_after_post_abort: got state=%0d, required 1", state_o);
        end
        pulse_ctrl(1'b0, 1'b1, 1'b0);

        pulse_ctrl(1'b1, 1'b0, 1'b0);
        modelWptr = 0;
        for (int i = 0; i < 16; i++) begin
            if (i == 4) modelTrig = modelWptr;
            send_sample(4'(i + 3), 1'b1);
        end
        testsRun++;
        if (state_o !== 3'd4) begin
            testsFailed++;
            $display("[TB] FAIL abort_setup_done: got state=%0d, required 4", state_o);
        end
        o_ready = 1'b0;
        expAddrQ.push_back(4'((modelTrig - 4 + 16) % 16));
        pulse_ctrl(1'b0, 1'b0, 1'b1);
        seen = 1'b0;
        for (int cyc = 0; cyc < 10 && !seen; cyc++) begin
            if (o_valid === 1'b1) seen = 1'b1;
            else begin
                @(posedge clk); #1;
            end
        end
        testsRun++;
        if (!seen) begin
            testsFailed++;
            $display("[TB] FAIL hold_timeout: got valid=%b, required 1 within 10 clks", o_valid);
        end
        pulse_ctrl(1'b0, 1'b1, 1'b0);
        testsRun++;
        if (state_o !== 3'd0 || o_valid !== 1'b0 || o_last !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL abort_in_rd_hold: got state=%0d valid=%b last=%b, required 0 0 0",
                     state_o, o_valid, o_last);
        end
        o_ready = 1'b1;
        pulse_ctrl(1'b1, 1'b0, 1'b0);
        modelWptr = 0;
        send_sample(4'h7, 1'b1);
        pulse_ctrl(1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_ignored_inputs;
        int reBefore;
        pulse_ctrl(1'b1, 1'b1, 1'b0);
        testsRun++;
        if (state_o !== 3'd0 || busy !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL arm_abort_same_clk: got state=%0d busy=%b, required 0 0",
                     state_o, busy);
        end
        send_sample(4'hB, 1'b0);
        testsRun++;
        if (ram_we !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL idle_no_write: got we=%b, required 0", ram_we);
        end
        trig_mask = 4'hF;
        trig_val = 4'hF;
        pulse_ctrl(1'b1, 1'b0, 1'b0);
        modelWptr = 0;
        for (int i = 0; i < 4; i++) send_sample(4'h0, 1'b1);
        reBefore = reSeen;
        pulse_ctrl(1'b0, 1'b0, 1'b1);
        @(posedge clk); #1;
        testsRun++;
        if (state_o !== 3'd2 || reSeen != reBefore) begin
            testsFailed++;
            $display("[TB] FAIL rd_start_in_wait: got state=%0d reads=%0d, required state=2 reads=0",
                     state_o, reSeen - reBefore);
        end
        pulse_ctrl(1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_async_reset;
        trig_mask = 4'h0;
        trig_val = 4'h0;
        pulse_ctrl(1'b1, 1'b0, 1'b0);
        modelWptr = 0;
        for (int i = 0; i < 6; i++) send_sample(4'(i + 8), 1'b1);
        @(posedge clk); #1;
        smpl_en = 1'b1; ch_data = 4'hC;
        @(posedge clk); #1;
        smpl_en = 1'b0;
        testsRun++;
        if (ram_we !== 1'b1 || state_o !== 3'd3) begin
            testsFailed++;
            $display("[TB] FAIL async_reset_setup: got we=%b state=%0d, required we=1 state=3",
                     ram_we, state_o);
        end
        #2;
        reset = 1'b0;
        #1;
        testsRun++;
        if ({ram_we, ram_waddr, ram_wdata, ram_re, ram_raddr, o_data, o_valid, o_last,
             state_o, busy} !== 24'h0) begin
            testsFailed++;
            $display("[TB] FAIL async_reset_clears: got state=%0d we=%b waddr=%0d wdata=%h data=%h, required all 0",
                     state_o, ram_we, ram_waddr, ram_wdata, o_data);
        end
        reset = 1'b1;
    endtask

    initial begin
        test_reset();
        test_basic_capture();
        test_pattern_present();
        test_wrap_trigger();
        test_abort();
        test_ignored_inputs();
        test_async_reset();
        repeat (3) @(posedge clk);
        #1;
        testsRun++;
        if (expWrQ.size() + expAddrQ.size() + expRdQ.size() != 0) begin
            testsFailed++;
            $display("[TB] FAIL queues_drained: got wr=%0d addr=%0d rd=%0d pending, required 0",
                     expWrQ.size(), expAddrQ.size(), expRdQ.size());
        end
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
